ddr_burst_writer: RTL and testbench
===================================

# ddr_burst_writer

Drain stage on the read side of the CPU→DDR async FIFO, in the `ddr_clk` domain. Pops 32-bit words from the FIFO and packs them into bursts of up to `BURST_LEN` words. Acquires the DDR write port through a request/grant handshake, then streams each burst out with an auto-incrementing word address. A flush timer bounds the latency of partial bursts.

## Interface
- `DATA_W`, 32, FIFO and memory data width
- `BURST_LEN`, 4, maximum words per burst (power of two, 2..16)
- `ADDR_W`, 16, word-address width
- `FLUSH_CYCLES`, 64, idle cycles before a partial burst is sent (≥2)

Ports:
- `ddr_clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `ddr_rst`  in  1  synchronous, active-high reset
- `enable`  in  1  allow new bursts to start
- `base_addr`  in  ADDR_W  start address, loaded at reset
- `fifo_rd_data`  in  DATA_W  FIFO read data, valid the cycle after `fifo_rd_en`
- `fifo_rd_empty`  in  1  FIFO empty
- `fifo_rd_en`  out  1  pop request (combinational)
- `mem_req`  out  1  write-port request (registered)
- `mem_grant`  in  1  write-port grant
- `mem_addr`  out  ADDR_W  burst start address, stable while `mem_req` or `mem_wvalid`
- `mem_len`  out  $clog2(BURST_LEN)+1  word count of current burst
- `mem_wdata`  out  DATA_W  burst data
- `mem_wvalid`  out  1  data beat valid
- `mem_wlast`  out  1  final beat of burst
- `bursts_done`  out  16  completed-burst count, wraps
- `status_out`  out  8  {state[1:0], buffer count[4:0], flush_hit}

## Operation
- Reset values: `mem_req`, `mem_wvalid`, `mem_wlast` = 0. `mem_wdata`, `bursts_done`, `status_out` = 0. `mem_len` = 0. `mem_addr` = `base_addr`. State = IDLE, buffer empty.
- State IDLE: move to FILL when `enable`=1.
- State FILL:
  - `fifo_rd_en` = !`fifo_rd_empty` && (count + inflight < BURST_LEN).
  - Data popped in cycle N is written to buffer slot `count` at edge N+1.
  - Move to REQ when count reaches BURST_LEN with no pop in flight.
  - Also move to REQ when the flush timer expires with count>0; set `flush_hit` sticky until the next burst.
  - With count=0 and `enable`=0, return to IDLE.
- Flush timer: cleared on every pop and on state exit; counts in FILL while count>0. Expiry at FLUSH_CYCLES.
- State REQ:
  - `mem_req`=1 and `mem_len`=count; no pops.
  - Hold until `mem_grant` is sampled 1, then go to SEND.
  - `mem_grant` outside REQ is ignored.
- State SEND:
  - One beat per cycle; `mem_wvalid`=1, beats come from buffer slots 0..count-1 in order.
  - `mem_wlast`=1 on beat count-1.
  - After the last beat: `mem_addr` += count, modulo 2^ADDR_W (wraps silently). `bursts_done`++, buffer cleared. Go to FILL if `enable`, else IDLE.
- `enable` deasserted in FILL/REQ/SEND: the current burst completes normally. Already-buffered words are still sent, via the flush path.
- Reset mid-operation: all state drops at once and buffered words are discarded. `mem_req`/`mem_wvalid` deassert at the reset edge.

## Timing
- Pop-to-buffer latency is 1 cycle.
- `mem_req` rises on the edge after the FILL→REQ decision.
- First beat is driven the cycle after `mem_grant` is sampled high. `mem_req` falls on that same edge.
- Full-burst throughput: BURST_LEN fill + 1 req + grant wait + BURST_LEN send cycles.
- Grant already high when REQ is entered: SEND starts the next cycle (minimum REQ duration is 1 cycle).
- `fifo_rd_empty` may toggle at any cycle. No pop is ever issued while empty is 1.

## Structure
- Package `ddr_burst_pkg`:
  - state enum {IDLE, FILL, REQ, SEND}
  - `status_out` bit positions
  - default `BURST_LEN` and `FLUSH_CYCLES`
- Sub-module `ddr_burst_buf`: BURST_LEN×DATA_W register array, with write-index, read-index and count. Top level holds the FSM, flush timer and address counter.

## Test plan
- `base_addr`=0x0100. Push 4 words A0..A3 with `mem_grant` tied high → one burst: `mem_addr`=0x0100, `mem_len`=4, beats A0..A3, `mem_wlast` on A3; then `mem_addr`=0x0104, `bursts_done`=1.
- Push 2 words then stop → after 64 idle cycles `mem_req`=1, `mem_len`=2, `flush_hit`=1. Two beats are sent, and `mem_addr` advances by 2.
- Burst ready, hold `mem_grant`=0 for 10 cycles → `mem_req` held high for 10 cycles; no pops and no beats; the burst completes after grant.
- `base_addr`=0xFFFE with a 4-word burst → next `mem_addr`=0x0002.
- Assert `ddr_rst` during SEND beat 2 → the next cycle has `mem_wvalid`=0, `mem_req`=0, state IDLE, count 0, and `bursts_done` unchanged.
- FIFO empty toggling every cycle → `fifo_rd_en` never high while empty. Eight words are delivered in order as two bursts.

Source files
------------

// File: rtl/ddr_burst_pkg.sv
// ddr_burst_pkg
// Shared definitions for the DDR burst writer: FSM state encoding, the bit
// layout of the status_out word and default burst/flush parameters.
// No ports; imported by ddr_burst_writer and ddr_burst_buf.

package ddr_burst_pkg;

    // IDLE must encode as zero so that status_out reads 0 straight out of reset
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        REQ  = 2'd2,
        SEND = 2'd3
    } state_e;

    // status_out = {state[1:0], buffer count[4:0], flush_hit}
    localparam int STAT_FLUSH_BIT = 0;
    localparam int STAT_CNT_LSB   = 1;
    localparam int STAT_CNT_W     = 5;
    localparam int STAT_STATE_LSB = 6;
    localparam int STAT_W         = 8;

    localparam int DEFAULT_BURST_LEN    = 4;
    localparam int DEFAULT_FLUSH_CYCLES = 64;

endpackage

// File: rtl/ddr_burst_buf.sv
// ddr_burst_buf
// Burst staging buffer: BURST_LEN x DATA_W register array. Words are appended
// at slot 'count' and read back in order from slot 0 through a read index.
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset
//   clear_i         empty the buffer (count and read index back to 0)
//   wr_en_i         append wr_data_i at slot count_o
//   wr_data_i       word to append
//   rd_adv_i        step the read index to the next slot
//   count_o         number of words held
//   rd_idx_o        slot currently presented on rd_data_o
//   rd_data_o       contents of slot rd_idx_o

module ddr_burst_buf
    import ddr_burst_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         wr_en_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         rd_adv_i,
    output logic [$clog2(BURST_LEN):0]   count_o,
    output logic [$clog2(BURST_LEN)-1:0] rd_idx_o,
    output logic [DATA_W-1:0]            rd_data_o
);

    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_LEN);

    logic [DATA_W-1:0] slots_q [BURST_LEN];
    logic [CNT_W-1:0]  count_q;
    logic [IDX_W-1:0]  rdIdx_q;
    logic              doWrite;

    // A full buffer silently refuses further writes so the count can never
    // run past BURST_LEN even if the producer misbehaves.
    assign doWrite = wr_en_i && (count_q < FULL_CNT);

    // Occupancy and read pointer; clearing takes priority over any update
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
            rdIdx_q <= '0;
        end else begin
            if (doWrite) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (rd_adv_i) begin
                rdIdx_q <= rdIdx_q + IDX_W'(1);
            end
        end
    end

    // Data slots carry no reset: a slot is only ever read after being written
    always_ff @(posedge clk_i) begin
        if (doWrite) begin
            slots_q[count_q[IDX_W-1:0]] <= wr_data_i;
        end
    end

    assign count_o   = count_q;
    assign rd_idx_o  = rdIdx_q;
    assign rd_data_o = slots_q[rdIdx_q];

endmodule

// File: rtl/ddr_burst_writer.sv
// ddr_burst_writer
// Drains the read side of the CPU->DDR async FIFO in the ddr_clk domain,
// packs words into bursts of up to BURST_LEN, arbitrates for the DDR write
// port with mem_req/mem_grant and streams each burst at an auto-incrementing
// word address. A flush timer sends partial bursts after FLUSH_CYCLES idle.
// Ports:
//   ddr_clk, ddr_rst         clock, synchronous active-high reset
//   enable                   allow new bursts to start
//   base_addr                start word address, loaded during reset
//   fifo_rd_data/_empty/_en  FIFO read side (data valid the cycle after _en)
//   mem_req/mem_grant        write-port request (registered) and grant
//   mem_addr, mem_len        burst start address and word count
//   mem_wdata/_wvalid/_wlast burst data beats
//   bursts_done              completed-burst counter (wraps)
//   status_out               {state, buffer count, flush_hit}

module ddr_burst_writer
    import ddr_burst_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int BURST_LEN    = DEFAULT_BURST_LEN,
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
    input  logic                         ddr_clk,
    input  logic                         ddr_rst,
    input  logic                         enable,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [DATA_W-1:0]            fifo_rd_data,
    input  logic                         fifo_rd_empty,
    output logic                         fifo_rd_en,
    output logic                         mem_req,
    input  logic                         mem_grant,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [$clog2(BURST_LEN):0]   mem_len,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         mem_wvalid,
    output logic                         mem_wlast,
    output logic [15:0]                  bursts_done,
    output logic [STAT_W-1:0]            status_out
);

    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int LEN_W = IDX_W + 1;
    localparam int TMR_W = $clog2(FLUSH_CYCLES);
    localparam logic [LEN_W-1:0] FULL_CNT   = LEN_W'(BURST_LEN);
    localparam logic [LEN_W:0]   POP_LIMIT  = (LEN_W + 1)'(BURST_LEN);
    localparam logic [TMR_W-1:0] FLUSH_LAST = TMR_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic              inflight_q;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       burstCnt_q;
    logic              flushHit_q;
    logic              memReq_q;
    logic [LEN_W-1:0]  len_q;

    logic [LEN_W-1:0]  bufCount;
    logic [IDX_W-1:0]  bufRdIdx;
    logic [DATA_W-1:0] bufRdData;
    logic [LEN_W:0]    fillLevel;
    logic              popEn;
    logic              lastBeat;
    logic              flushFire;

    // Words already requested but not yet landed count against the space
    // left, so a pop is never issued that the buffer could not accept.
    assign fillLevel = {1'b0, bufCount} + {{LEN_W{1'b0}}, inflight_q};
    assign popEn     = (state_q == FILL) && !fifo_rd_empty && (fillLevel < POP_LIMIT);
    assign lastBeat  = (state_q == SEND) && ({1'b0, bufRdIdx} == (bufCount - LEN_W'(1)));

    ddr_burst_buf #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) u_buf (
        .clk_i     (ddr_clk),
        .rst_i     (ddr_rst),
        .clear_i   (lastBeat),
        .wr_en_i   (inflight_q),
        .wr_data_i (fifo_rd_data),
        .rd_adv_i  ((state_q == SEND) && !lastBeat),
        .count_o   (bufCount),
        .rd_idx_o  (bufRdIdx),
        .rd_data_o (bufRdData)
    );

    // Next-state logic. Every exit from FILL waits for the in-flight pop to
    // land so a word can never be lost between the FIFO and the buffer.
    always_comb begin
        state_d   = state_q;
        flushFire = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if ((bufCount == FULL_CNT) && !inflight_q) begin
                    state_d = REQ;
                end else if ((bufCount != '0) && (timer_q >= FLUSH_LAST) &&
                             !inflight_q && !popEn) begin
                    state_d   = REQ;
                    flushFire = 1'b1;
                end else if ((bufCount == '0) && !enable && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_grant) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (lastBeat) begin
                    state_d = enable ? FILL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush timer: restarts on every pop and every state change, and only
    // advances while a partial burst is waiting in FILL. It saturates at
    // FLUSH_LAST, so expiry stays asserted until the transition can be taken.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || popEn) begin
            timer_d = '0;
        end else if ((state_q == FILL) && (bufCount != '0) && (timer_q < FLUSH_LAST)) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // State, request, burst length, address and statistics registers.
    // mem_req is registered from the next state so it rises on the edge after
    // the FILL->REQ decision and drops on the edge that starts SEND.
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            timer_q    <= '0;
            addr_q     <= base_addr;
            burstCnt_q <= '0;
            flushHit_q <= 1'b0;
            memReq_q   <= 1'b0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= popEn;
            timer_q    <= timer_d;
            memReq_q   <= (state_d == REQ);
            if ((state_q == FILL) && (state_d == REQ)) begin
                len_q      <= bufCount;
                flushHit_q <= flushFire;
            end
            if (lastBeat) begin
                addr_q     <= addr_q + ADDR_W'(bufCount);
                burstCnt_q <= burstCnt_q + 16'd1;
            end
        end
    end

    assign fifo_rd_en  = popEn;
    assign mem_req     = memReq_q;
    assign mem_addr    = addr_q;
    assign mem_len     = len_q;
    assign mem_wvalid  = (state_q == SEND);
    assign mem_wlast   = lastBeat;
    assign mem_wdata   = (state_q == SEND) ? bufRdData : '0;
    assign bursts_done = burstCnt_q;

    // Status word assembled from the package bit positions
    always_comb begin
        status_out = '0;
        status_out[STAT_STATE_LSB +: 2]        = state_q;
        status_out[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(bufCount);
        status_out[STAT_FLUSH_BIT]             = flushHit_q;
    end

endmodule

// File: tb/tb_ddr_burst_writer.sv
// tb_ddr_burst_writer
// Self-checking bench for ddr_burst_writer. A queue-based FIFO feeds the DUT;
// the reference model tracks the ordered word stream, the expected burst
// lengths, the running word address and the burst count.

module tb_ddr_burst_writer;

    localparam int DATA_W       = 32;
    localparam int BURST_LEN    = 4;
    localparam int ADDR_W       = 16;
    localparam int FLUSH_CYCLES = 64;
    localparam int LEN_W        = $clog2(BURST_LEN) + 1;

    logic              ddrClk;
    logic              ddrRst;
    logic              enable;
    logic [ADDR_W-1:0] baseAddr;
    logic [DATA_W-1:0] fifoRdData;
    logic              fifoRdEmpty;
    logic              fifoRdEn;
    logic              memReq;
    logic              memGrant;
    logic [ADDR_W-1:0] memAddr;
    logic [LEN_W-1:0]  memLen;
    logic [DATA_W-1:0] memWdata;
    logic              memWvalid;
    logic              memWlast;
    logic [15:0]       burstsDone;
    logic [7:0]        statusOut;

    ddr_burst_writer #(
        .DATA_W       (DATA_W),
        .BURST_LEN    (BURST_LEN),
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .ddr_clk       (ddrClk),
        .ddr_rst       (ddrRst),
        .enable        (enable),
        .base_addr     (baseAddr),
        .fifo_rd_data  (fifoRdData),
        .fifo_rd_empty (fifoRdEmpty),
        .fifo_rd_en    (fifoRdEn),
        .mem_req       (memReq),
        .mem_grant     (memGrant),
        .mem_addr      (memAddr),
        .mem_len       (memLen),
        .mem_wdata     (memWdata),
        .mem_wvalid    (memWvalid),
        .mem_wlast     (memWlast),
        .bursts_done   (burstsDone),
        .status_out    (statusOut)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        ddrClk = 1'b0;
        forever #5 ddrClk = ~ddrClk;
    end

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] fifoQ[$];
    logic [DATA_W-1:0] expWords[$];
    int                expLens[$];
    logic [ADDR_W-1:0] modelAddr;
    int                modelBursts;
    int                beatIdx;
    int                curLen;

    bit   toggleMode;
    bit   emptyPhase;
    bit   randEmpty;
    bit   randGrant;
    bit   prevReqGrant;
    int   cycle;
    int   lastPopCycle;
    int   firstReqCycle;
    logic [7:0]       reqStatus;
    logic [LEN_W-1:0] reqLen;
    int   reqCount;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Queue a word in the FIFO and in the expected output stream
    task automatic pushWord(input logic [DATA_W-1:0] w);
        fifoQ.push_back(w);
        expWords.push_back(w);
    endtask

    // Score one data beat against the model's next expected word and burst
    task automatic monitorBeat();
        logic [DATA_W-1:0] w;
        if (beatIdx == 0) begin
            checkOutput("burstExpected", expLens.size() != 0, 1);
            curLen = (expLens.size() != 0) ? expLens.pop_front() : 1;
        end
        checkOutput("spareWord", expWords.size() != 0, 1);
        w = (expWords.size() != 0) ? expWords.pop_front() : '0;
        checkOutput("burstAddr", memAddr, modelAddr);
        checkOutput("burstLen", memLen, curLen);
        checkOutput("beatData", memWdata, w);
        checkOutput("beatLast", memWlast, beatIdx == curLen - 1);
        beatIdx++;
        if (beatIdx == curLen) begin
            beatIdx     = 0;
            modelAddr   = modelAddr + ADDR_W'(curLen);
            modelBursts = modelBursts + 1;
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, sample outputs just
    // after, then model the FIFO's registered read data after the rising edge
    task automatic applyStimulus();
        bit popNow;
        if (toggleMode) begin
            emptyPhase  = !emptyPhase;
            fifoRdEmpty = (fifoQ.size() == 0) || emptyPhase;
        end else if (randEmpty) begin
            fifoRdEmpty = (fifoQ.size() == 0) || ($urandom_range(0, 2) == 0);
        end else begin
            fifoRdEmpty = (fifoQ.size() == 0);
        end
        if (randGrant) begin
            memGrant = ($urandom_range(0, 3) == 0);
        end
        #1;
        popNow = fifoRdEn;
        checkOutput("popWhileEmpty", fifoRdEn & fifoRdEmpty, 0);
        if (memReq) begin
            checkOutput("popDuringReq", fifoRdEn, 0);
            checkOutput("beatDuringReq", memWvalid, 0);
            if (firstReqCycle < 0) begin
                firstReqCycle = cycle;
                reqStatus     = statusOut;
                reqLen        = memLen;
            end
        end
        if (prevReqGrant) begin
            checkOutput("beatAfterGrant", memWvalid, 1);
            checkOutput("reqDropAfterGrant", memReq, 0);
        end
        prevReqGrant = memReq && memGrant && !ddrRst;
        if (memWvalid) begin
            monitorBeat();
        end
        @(posedge ddrClk);
        #1;
        if (popNow && fifoQ.size() != 0) begin
            lastPopCycle = cycle;
            fifoRdData   = fifoQ.pop_front();
        end else begin
            fifoRdData = $urandom();
        end
        cycle++;
        @(negedge ddrClk);
    endtask

    // Run until every queued word has been delivered, within a cycle budget
    task automatic drain(input int bound);
        int n = 0;
        while ((expLens.size() != 0 || beatIdx != 0 || fifoQ.size() != 0) && n < bound) begin
            applyStimulus();
            n++;
        end
        checkOutput("drainDone", (expLens.size() == 0) && (beatIdx == 0) && (fifoQ.size() == 0), 1);
    endtask

    // Hold reset for three cycles and restart the model from base
    task automatic holdReset(input logic [ADDR_W-1:0] base);
        ddrRst   = 1'b1;
        baseAddr = base;
        fifoQ.delete();
        expWords.delete();
        expLens.delete();
        beatIdx      = 0;
        prevReqGrant = 0;
        repeat (3) applyStimulus();
        modelAddr   = base;
        modelBursts = 0;
    endtask

    initial begin
        ddrRst        = 1'b1;
        enable        = 1'b0;
        baseAddr      = 16'h0100;
        fifoRdData    = '0;
        fifoRdEmpty   = 1'b1;
        memGrant      = 1'b1;
        toggleMode    = 0;
        emptyPhase    = 0;
        randEmpty     = 0;
        randGrant     = 0;
        prevReqGrant  = 0;
        cycle         = 0;
        lastPopCycle  = 0;
        firstReqCycle = -1;
        beatIdx       = 0;
        curLen        = 0;
        modelAddr     = 16'h0100;
        modelBursts   = 0;
        @(negedge ddrClk);

        // Reset values
        holdReset(16'h0100);
        checkOutput("rstReq", memReq, 0);
        checkOutput("rstWvalid", memWvalid, 0);
        checkOutput("rstWlast", memWlast, 0);
        checkOutput("rstWdata", memWdata, 0);
        checkOutput("rstLen", memLen, 0);
        checkOutput("rstAddr", memAddr, 16'h0100);
        checkOutput("rstBursts", burstsDone, 0);
        checkOutput("rstStatus", statusOut, 0);
        checkOutput("rstPop", fifoRdEn, 0);
        ddrRst = 1'b0;
        enable = 1'b1;

        // Full burst with grant tied high
        repeat (4) pushWord($urandom());
        expLens.push_back(4);
        drain(100);
        checkOutput("fullAddrNext", memAddr, 16'h0104);
        checkOutput("fullBursts", burstsDone, 1);

        // Partial burst sent by the flush timer
        firstReqCycle = -1;
        repeat (2) pushWord($urandom());
        expLens.push_back(2);
        for (int i = 0; i < 150 && firstReqCycle < 0; i++) applyStimulus();
        checkOutput("flushReqSeen", firstReqCycle >= 0, 1);
        checkOutput("flushDelayMin", (firstReqCycle - lastPopCycle) >= FLUSH_CYCLES, 1);
        checkOutput("flushDelayMax", (firstReqCycle - lastPopCycle) <= FLUSH_CYCLES + 6, 1);
        checkOutput("flushHit", reqStatus[0], 1);
        checkOutput("flushLen", reqLen, 2);
        drain(50);
        checkOutput("flushAddrNext", memAddr, 16'h0106);
        checkOutput("flushBursts", burstsDone, modelBursts);

        // Grant withheld for ten cycles while more words wait in the FIFO
        memGrant      = 1'b0;
        firstReqCycle = -1;
        repeat (8) pushWord($urandom());
        expLens.push_back(4);
        expLens.push_back(4);
        for (int i = 0; i < 100 && firstReqCycle < 0; i++) applyStimulus();
        checkOutput("holdReqSeen", firstReqCycle >= 0, 1);
        checkOutput("holdFlushClear", reqStatus[0], 0);
        reqCount = 0;
        for (int i = 0; i < 10; i++) begin
            reqCount += memReq;
            applyStimulus();
        end
        checkOutput("holdReqCycles", reqCount, 10);
        checkOutput("holdNoPop", fifoQ.size(), 4);
        memGrant = 1'b1;
        drain(100);
        checkOutput("holdAddrNext", memAddr, modelAddr);
        checkOutput("holdBursts", burstsDone, modelBursts);

        // FIFO empty toggling every cycle
        toggleMode = 1;
        repeat (8) pushWord($urandom());
        expLens.push_back(4);
        expLens.push_back(4);
        drain(300);
        toggleMode = 0;
        checkOutput("toggleBursts", burstsDone, modelBursts);

        // Randomized empties and grant latency
        randEmpty = 1;
        randGrant = 1;
        for (int r = 0; r < 6; r++) begin
            int nb;
            nb = $urandom_range(1, 3);
            repeat (nb * 4) pushWord($urandom());
            repeat (nb) expLens.push_back(4);
            drain(600);
            checkOutput("randAddr", memAddr, modelAddr);
            checkOutput("randBursts", burstsDone, modelBursts);
        end
        randEmpty = 0;
        randGrant = 0;
        memGrant  = 1'b1;

        // Disabled with an empty buffer returns to IDLE
        enable = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("idleWhenDisabled", statusOut[7:6], 0);
        enable = 1'b1;

        // Reset during the second beat of a burst
        holdReset(16'h0200);
        ddrRst = 1'b0;
        repeat (4) pushWord($urandom());
        expLens.push_back(4);
        for (int i = 0; i < 60 && beatIdx != 1; i++) applyStimulus();
        checkOutput("midSendReached", beatIdx, 1);
        ddrRst = 1'b1;
        applyStimulus();
        checkOutput("midRstWvalid", memWvalid, 0);
        checkOutput("midRstReq", memReq, 0);
        checkOutput("midRstState", statusOut[7:6], 0);
        checkOutput("midRstCount", statusOut[5:1], 0);
        checkOutput("midRstBursts", burstsDone, modelBursts);
        checkOutput("midRstAddr", memAddr, modelAddr);
        fifoQ.delete();
        expWords.delete();
        expLens.delete();
        beatIdx      = 0;
        prevReqGrant = 0;
        ddrRst       = 1'b0;

        // Address wrap from 0xFFFE
        holdReset(16'hFFFE);
        ddrRst = 1'b0;
        repeat (4) pushWord($urandom());
        expLens.push_back(4);
        drain(100);
        checkOutput("wrapAddr", memAddr, 16'h0002);
        checkOutput("wrapBursts", burstsDone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
